// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Shared DSP types, FSM encodings and the rounding/narrowing
//               helper used by the serial IIR/FIR datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

    localparam int c_COEF_FRAC_DEFAULT = 14;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_MAC   = 2'd1;
    localparam state_t c_ST_ROUND = 2'd2;
    localparam state_t c_ST_OUT   = 2'd3;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } narrow_t;

    // Round half up, drop frac bits, then clamp to bw bits when sat_en is set.
    // Without sat_en the caller keeps the low bw bits, which is a wrap.
    function automatic narrow_t round_shift_sat(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 bw,
        input logic               sat_en
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        narrow_t            res;
        r         = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi        = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo        = -(64'sd1 <<< (bw - 1));
        res.value = r;
        res.sat   = 1'b0;
        if (sat_en) begin
            if (r > hi) begin
                res.value = hi;
                res.sat   = 1'b1;
            end else if (r < lo) begin
                res.value = lo;
                res.sat   = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_mac.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac
// Description : Registered multiply-subtract accumulator with load and enable:
//               acc <= load ? load_val : en ? acc - a*b : acc.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_en,
    input  logic signed [ACC_W-1:0] i_load_val,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [A_W+B_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_acc_d;
    logic signed [ACC_W-1:0]   r_acc_q;

    assign w_prod = (A_W+B_W)'(i_a) * (A_W+B_W)'(i_b);

    always_comb begin
        w_acc_d = r_acc_q;
        if (i_load) begin
            w_acc_d = i_load_val;
        end else if (i_en) begin
            w_acc_d = r_acc_q - ACC_W'(w_prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q <= '0;
        end else begin
            r_acc_q <= w_acc_d;
        end
    end

    assign o_acc = r_acc_q;

endmodule
`default_nettype wire

// File: rtl/iir_allpole_serial.sv
`default_nettype none
// ============================================================================
// Module      : iir_allpole_serial
// Description : Folded all-pole IIR, y[n] = x[n] - sum a[k]*y[n-k], one MAC
//               iterated over N taps. Define IIR_ALLPOLE_SAT_EN to saturate
//               the output (adds sat_flag); otherwise the output wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_allpole_serial
    import dsp_pkg::*;
#(
    parameter int BITWIDTH  = 16,
    parameter int ACCWIDTH  = 40,
    parameter int N         = 16,
    parameter int COEF_FRAC = c_COEF_FRAC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [BITWIDTH-1:0] coeffs [N-1:0],
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BITWIDTH-1:0] out_data,
    output logic                       busy
`ifdef IIR_ALLPOLE_SAT_EN
    ,
    output logic                       sat_flag
`endif
);

    localparam int c_K_W = (N > 1) ? $clog2(N) : 1;
`ifdef IIR_ALLPOLE_SAT_EN
    localparam logic c_SAT_EN = 1'b1;
`else
    localparam logic c_SAT_EN = 1'b0;
`endif

    generate
        if (ACCWIDTH < 2*BITWIDTH + $clog2(N) + 1 || ACCWIDTH > 64) begin : g_bad_accwidth
            $error("iir_allpole_serial: ACCWIDTH out of range");
        end
    endgenerate

    state_t                     r_state_q, w_state_d;
    logic [c_K_W-1:0]           r_k_q, w_k_d;
    logic signed [BITWIDTH-1:0] r_hist_q [N-1:0];
    logic signed [BITWIDTH-1:0] w_hist_d [N-1:0];
    logic signed [BITWIDTH-1:0] r_out_data_q, w_out_data_d;
    logic                       r_out_valid_q, w_out_valid_d;
    logic                       w_mac_load, w_mac_en;
    logic signed [ACCWIDTH-1:0] w_mac_load_val;
    logic signed [ACCWIDTH-1:0] w_acc;
    narrow_t                    w_narrow;
    logic signed [BITWIDTH-1:0] w_y;

    dsp_mac #(
        .A_W   (BITWIDTH),
        .B_W   (BITWIDTH),
        .ACC_W (ACCWIDTH)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_mac_load),
        .i_en       (w_mac_en),
        .i_load_val (w_mac_load_val),
        .i_a        (coeffs[r_k_q]),
        .i_b        (r_hist_q[r_k_q]),
        .o_acc      (w_acc)
    );

    assign w_narrow = round_shift_sat(64'(w_acc), COEF_FRAC, BITWIDTH, c_SAT_EN);
    assign w_y      = w_narrow.value[BITWIDTH-1:0];

`ifdef IIR_ALLPOLE_SAT_EN
    logic r_sat_q, w_sat_d;
    logic w_unused_bits;
    assign w_unused_bits = ^{w_narrow.value[63:BITWIDTH]};
    assign sat_flag      = r_sat_q;
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{w_narrow.value[63:BITWIDTH], w_narrow.sat};
`endif

    always_comb begin
        w_state_d      = r_state_q;
        w_k_d          = r_k_q;
        w_hist_d       = r_hist_q;
        w_out_data_d   = r_out_data_q;
        w_out_valid_d  = r_out_valid_q;
        w_mac_load     = 1'b0;
        w_mac_en       = 1'b0;
        w_mac_load_val = '0;
`ifdef IIR_ALLPOLE_SAT_EN
        w_sat_d        = r_sat_q;
`endif
        case (r_state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_mac_load     = 1'b1;
                    w_mac_load_val = ACCWIDTH'(in_data) <<< COEF_FRAC;
                    w_k_d          = '0;
                    w_state_d      = c_ST_MAC;
                end
            end
            c_ST_MAC: begin
                w_mac_en = 1'b1;
                if (r_k_q == c_K_W'(N - 1)) begin
                    w_state_d = c_ST_ROUND;
                end else begin
                    w_k_d = r_k_q + 1'b1;
                end
            end
            c_ST_ROUND: begin
                // History keeps the narrowed y so feedback matches the output.
                w_out_data_d  = w_y;
                w_hist_d[0]   = w_y;
                for (int i = 1; i < N; i++) begin
                    w_hist_d[i] = r_hist_q[i-1];
                end
                w_out_valid_d = 1'b1;
`ifdef IIR_ALLPOLE_SAT_EN
                w_sat_d       = w_narrow.sat;
`endif
                w_state_d     = c_ST_OUT;
            end
            default: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = c_ST_IDLE;
                end
            end
        endcase

        if (flush) begin
            for (int i = 0; i < N; i++) begin
                w_hist_d[i] = '0;
            end
            w_out_valid_d  = 1'b0;
            w_state_d      = c_ST_IDLE;
            w_k_d          = '0;
            w_mac_load     = 1'b1;
            w_mac_load_val = '0;
            w_mac_en       = 1'b0;
`ifdef IIR_ALLPOLE_SAT_EN
            w_sat_d        = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_k_q         <= '0;
            r_out_data_q  <= '0;
            r_out_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_hist_q[i] <= '0;
            end
`ifdef IIR_ALLPOLE_SAT_EN
            r_sat_q       <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_k_q         <= w_k_d;
            r_out_data_q  <= w_out_data_d;
            r_out_valid_q <= w_out_valid_d;
            r_hist_q      <= w_hist_d;
`ifdef IIR_ALLPOLE_SAT_EN
            r_sat_q       <= w_sat_d;
`endif
        end
    end

    assign in_ready  = (r_state_q == c_ST_IDLE);
    assign busy      = (r_state_q != c_ST_IDLE);
    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_allpole_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_allpole_serial
// Description : Self-checking bench for iir_allpole_serial against an
//               arithmetic reference of the recurrence (IIR_ALLPOLE_SAT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_allpole_serial;

    localparam int BW  = 16;
    localparam int N   = 16;
    localparam int F   = 14;
    localparam int LAT = N + 2;

    logic                 clk = 1'b0;
    logic                 rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic signed [BW-1:0] in_data, out_data;
    logic signed [BW-1:0] cf [N-1:0];
    logic                 w_sat;
`ifdef IIR_ALLPOLE_SAT_EN
    logic                 sat_flag;
    assign w_sat = sat_flag;
`else
    assign w_sat = 1'b0;
`endif

    int     errors = 0;
    int     checks = 0;
    longint mh [N];

    always #5 clk = ~clk;

    iir_allpole_serial #(
        .BITWIDTH(BW), .ACCWIDTH(40), .N(N), .COEF_FRAC(F)
    ) dut (
        .clk(clk), .rst(rst), .coeffs(cf), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
`ifdef IIR_ALLPOLE_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) mh[k] = 0;
    endtask

    // y = round(x - sum a[k]*y[n-k]) in real terms, narrowed to 16 bits.
    function automatic void model_step(input longint x, output longint y, output bit s);
        longint acc, r;
        acc = x * (64'sd1 << F);
        for (int k = 0; k < N; k++) acc -= longint'(cf[k]) * mh[k];
        r = (acc + (64'sd1 << (F - 1))) >>> F;
        s = 1'b0;
`ifdef IIR_ALLPOLE_SAT_EN
        if (r > 32767) begin y = 32767; s = 1'b1; end
        else if (r < -32768) begin y = -32768; s = 1'b1; end
        else y = r;
`else
        y = r & 64'hFFFF;
        if (y > 32767) y -= 65536;
`endif
        for (int k = N - 1; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = y;
    endfunction

    // Drives one sample with out_ready=1; lat counts edges from acceptance to handshake.
    task automatic run_sample(input logic signed [BW-1:0] x, output longint y,
                              output logic s, output int lat, output bit ok);
        int n;
        ok = 1'b0; lat = 0; y = 0; s = 1'b0;
        in_data = x; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (!in_ready) begin in_valid = 1'b0; return; end
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        if (!out_valid) return;
        y = longint'(out_data);
        s = w_sat;
        tick();
        lat++;
        ok = 1'b1;
    endtask

    task automatic do_flush();
        flush = 1'b1; tick(); flush = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        for (int k = 0; k < N; k++) cf[k] = '0;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'sd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b out_data=%0d required 1 0 0 0",
                     in_ready, busy, out_valid, out_data);
        end
`ifdef IIR_ALLPOLE_SAT_EN
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat_flag: got %b required 0", sat_flag);
        end
`endif
    endtask

    task automatic test_impulse();
        longint exp_v [4] = '{16384, 8192, 4096, 2048};
        longint ins [4] = '{16384, 0, 0, 0};
        longint y, ym; logic s; bit sm; int lat; bit ok;
        cf[0] = -16'sd8192;
        for (int i = 0; i < 4; i++) begin
            run_sample(BW'(ins[i]), y, s, lat, ok);
            model_step(ins[i], ym, sm);
            checks++;
            if (!ok || y != exp_v[i] || lat != LAT) begin
                errors++;
                $display("FAIL impulse[%0d]: got %0d lat %0d ok %0b required %0d lat %0d",
                         i, y, lat, ok, exp_v[i], LAT);
            end
        end
    endtask

    task automatic test_rounding();
        longint y, ym; logic s; bit sm; int lat; bit ok;
        // flush in IDLE with a valid sample present must not accept it
        in_data = 16'sd1; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        model_clear();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_blocks_accept: busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            run_sample((i == 0) ? 16'sd1 : 16'sd0, y, s, lat, ok);
            model_step((i == 0) ? 1 : 0, ym, sm);
            checks++;
            if (!ok || y != 1) begin
                errors++;
                $display("FAIL rounding[%0d]: got %0d ok %0b required 1", i, y, ok);
            end
        end
    endtask

    task automatic test_saturation();
        longint y, ym; logic s; bit sm; int lat; bit ok;
        do_flush();
        cf[0] = -16'sd16384;
        run_sample(16'sd20000, y, s, lat, ok);
        model_step(20000, ym, sm);
        checks++;
        if (!ok || y != 20000) begin
            errors++;
            $display("FAIL sat_first: got %0d required 20000", y);
        end
        run_sample(16'sd20000, y, s, lat, ok);
        model_step(20000, ym, sm);
`ifdef IIR_ALLPOLE_SAT_EN
        checks++;
        if (!ok || y != 32767 || s !== 1'b1) begin
            errors++;
            $display("FAIL sat_second: got %0d flag %b required 32767 flag 1", y, s);
        end
`else
        checks++;
        if (!ok || y != -25536) begin
            errors++;
            $display("FAIL wrap_second: got %0d required -25536", y);
        end
`endif
    endtask

    task automatic test_backpressure();
        longint ym; bit sm; int n; logic signed [BW-1:0] held;
        do_flush();
        cf[0] = -16'sd8192;
        out_ready = 1'b0; in_data = 16'sd1000; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
        model_step(1000, ym, sm);
        held = out_data;
        checks++;
        if (out_valid !== 1'b1 || longint'(held) != 1000) begin
            errors++;
            $display("FAIL bp_output: valid=%b data=%0d required 1 1000", out_valid, held);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%0d busy=%b in_ready=%b required 1 %0d 1 0",
                         c, out_valid, out_data, busy, in_ready, held);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    // use_rst=0 aborts with flush, use_rst=1 with rst, both at tap index 3.
    task automatic test_abort_midmac(input bit use_rst);
        longint y, ym; logic s; bit sm; int lat; bit ok; int seen;
        do_flush();
        cf[0] = -16'sd8192;
        run_sample(16'sd10000, y, s, lat, ok);
        model_step(10000, ym, sm);
        checks++;
        if (!ok || y != 10000) begin
            errors++;
            $display("FAIL abort_prime[%0d]: got %0d required 10000", use_rst, y);
        end
        in_data = 16'sd7; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        model_clear();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle[%0d]: in_ready=%b valid=%b busy=%b required 1 0 0",
                     use_rst, in_ready, out_valid, busy);
        end
        seen = 0;
        for (int c = 0; c < N + 6; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_output[%0d]: got %0d valid cycles required 0", use_rst, seen);
        end
        run_sample(16'sd16384, y, s, lat, ok);
        model_step(16384, ym, sm);
        checks++;
        if (!ok || y != 16384) begin
            errors++;
            $display("FAIL abort_history[%0d]: got %0d required 16384", use_rst, y);
        end
    endtask

    task automatic test_roundtrip();
        longint xh [4];
        longint x, e, y, ym, d; logic s; bit sm; int lat; bit ok;
        do_flush();
        for (int k = 0; k < N; k++) cf[k] = '0;
        for (int k = 0; k < 4; k++) begin
            cf[k] = BW'(int'($urandom_range(800)) - 400);
            xh[k] = 0;
        end
        for (int i = 0; i < 1000; i++) begin
            x = longint'(int'($urandom_range(16000)) - 8000);
            e = x * 16384;
            for (int k = 0; k < 4; k++) e += longint'(cf[k]) * xh[k];
            e = (e + 8192) >>> 14;
            for (int k = 3; k > 0; k--) xh[k] = xh[k-1];
            xh[0] = x;
            run_sample(BW'(e), y, s, lat, ok);
            model_step(e, ym, sm);
            d = y - x;
            checks++;
            if (!ok || y != ym || lat != LAT) begin
                errors++;
                $display("FAIL roundtrip_model[%0d]: got %0d lat %0d required %0d lat %0d", i, y, lat, ym, LAT);
            end
            checks++;
            if (d > 1 || d < -1) begin
                errors++;
                $display("FAIL roundtrip_recon[%0d]: got %0d required %0d +-1", i, y, x);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_abort_midmac(1'b0);
        test_abort_midmac(1'b1);
        test_roundtrip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
